text_blit: RTL and testbench

Parametrised block fill/move engine for the terminal's character buffer. It clears rows, scrolls the screen up or down, and fills arbitrary ranges with a fixed character/attribute word. It is the successor of the fixed fill/offset writer inside `top`, generalised in address and data width, with three modes and a request/grant port. It sits between the terminal control logic (command side) and the shared text RAM arbiter, which also serves VGA scan-out (memory side).

---
 rtl/term_pkg.sv | 19 +
 rtl/text_blit.sv | 170 +++++++++++++++++
 tb/tb_text_blit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/term_pkg.sv
// Shared terminal constants: blit engine mode codes, FSM states and screen geometry.
package term_pkg;

  localparam logic [1:0] BLIT_FILL      = 2'd0;
  localparam logic [1:0] BLIT_COPY_UP   = 2'd1;
  localparam logic [1:0] BLIT_COPY_DOWN = 2'd2;

  localparam int TERM_COLS = 80;
  localparam int TERM_ROWS = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } blit_state_e;

endpackage

// File: rtl/text_blit.sv
// Block fill / scroll engine for the text RAM: fills a range with one word or
// moves a range up/down by an offset, one access per granted memory cycle.
module text_blit
  import term_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] cmd_begin,
  input  logic [ADDR_W-1:0] cmd_end,
  input  logic [ADDR_W-1:0] cmd_offset,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  blit_state_e       state_r;
  logic [ADDR_W-1:0] begin_r;
  logic [ADDR_W-1:0] end_r;
  logic [ADDR_W-1:0] offset_r;
  logic [ADDR_W-1:0] dst_r;
  logic              down_r;
  logic              first_r;
  logic [DATA_W-1:0] hold_r;

  logic              is_copy_s;
  logic              is_down_s;
  logic [ADDR_W-1:0] first_dst_s;
  logic [ADDR_W-1:0] next_dst_s;
  logic              last_cell_s;

  // Source cell for a destination; wraps modulo the address space.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [ADDR_W-1:0] dst,
                                                 input logic [ADDR_W-1:0] off,
                                                 input logic              down);
    return down ? (dst - off) : (dst + off);
  endfunction

  // Command decode and destination stepping.
  always_comb begin
    is_down_s   = (mode == BLIT_COPY_DOWN);
    is_copy_s   = (mode == BLIT_COPY_UP) || is_down_s;
    first_dst_s = is_down_s ? (cmd_end - ADDR_W'(1)) : cmd_begin;
    next_dst_s  = down_r ? (dst_r - ADDR_W'(1)) : (dst_r + ADDR_W'(1));
    last_cell_s = down_r ? (dst_r == begin_r) : (next_dst_s == end_r);
  end

  // The read word goes straight out in the first WRITE cycle; afterwards the
  // held copy covers stalls, since mem_rdata is only valid for one cycle.
  assign mem_wdata = (state_r == ST_WRITE && first_r) ? mem_rdata : hold_r;

  // Command sequencer: one transfer per granted cycle, outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      hold_r   <= '0;
      begin_r  <= '0;
      end_r    <= '0;
      offset_r <= '0;
      dst_r    <= '0;
      down_r   <= 1'b0;
      first_r  <= 1'b0;
    end else if (start && !busy) begin
      begin_r  <= cmd_begin;
      end_r    <= cmd_end;
      offset_r <= cmd_offset;
      down_r   <= is_down_s;
      first_r  <= 1'b0;
      hold_r   <= cmd_data;
      busy     <= 1'b1;
      if (cmd_begin >= cmd_end) begin
        // Empty range: report completion at once without touching memory.
        state_r <= ST_FINISH;
        done    <= 1'b1;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end else if (is_copy_s) begin
        state_r  <= ST_READ;
        done     <= 1'b0;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        dst_r    <= first_dst_s;
        mem_addr <= src_addr(first_dst_s, cmd_offset, is_down_s);
      end else begin
        state_r  <= ST_FILL;
        done     <= 1'b0;
        mem_req  <= 1'b1;
        mem_we   <= 1'b1;
        dst_r    <= cmd_begin;
        mem_addr <= cmd_begin;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
        end
        ST_FILL: begin
          if (mem_gnt) begin
            if (last_cell_s) begin
              state_r <= ST_FINISH;
              busy    <= 1'b0;
              done    <= 1'b1;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end else begin
              dst_r    <= next_dst_s;
              mem_addr <= next_dst_s;
            end
          end
        end
        ST_READ: begin
          if (mem_gnt) begin
            state_r  <= ST_WRITE;
            mem_we   <= 1'b1;
            mem_addr <= dst_r;
            first_r  <= 1'b1;
          end
        end
        ST_WRITE: begin
          first_r <= 1'b0;
          if (first_r) begin
            hold_r <= mem_rdata;
          end
          if (mem_gnt) begin
            if (last_cell_s) begin
              state_r <= ST_FINISH;
              busy    <= 1'b0;
              done    <= 1'b1;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end else begin
              state_r  <= ST_READ;
              mem_we   <= 1'b0;
              dst_r    <= next_dst_s;
              mem_addr <= src_addr(next_dst_s, offset_r, down_r);
            end
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_blit.sv
// Scoreboard bench for text_blit: a sequential reference model of each command
// predicts every memory access and the done cycle; monitors pop and compare.
module tb_text_blit;
  import term_pkg::*;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] cmd_begin = '0;
  logic [AW-1:0] cmd_end = '0;
  logic [AW-1:0] cmd_offset = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          busy, done, mem_req, mem_we;
  logic          mem_gnt = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  typedef struct { bit we; int addr; int data; } acc_t;
  typedef struct { int cyc; bit busy; } done_t;

  acc_t       exp_q[$];
  done_t      done_q[$];
  acc_t       mon_a;
  done_t      mon_d;
  logic [7:0] ram[DEPTH];
  logic [7:0] mdl[DEPTH];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         preload = 1'b0;
  int         preload_kind = 0;

  text_blit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .cmd_begin(cmd_begin), .cmd_end(cmd_end), .cmd_offset(cmd_offset), .cmd_data(cmd_data),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Text RAM behind the arbiter; shares the reset, read data only valid after a granted read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= (preload_kind == 0) ? i[7:0] : 8'hEE;
    end else if (!rst && mem_req && mem_gnt) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  // Access monitor.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt) begin
      check("access_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_a = exp_q.pop_front();
        check("acc_we", mem_we, mon_a.we);
        check("acc_addr", mem_addr, mon_a.addr);
        if (mon_a.we) check("acc_wdata", mem_wdata, mon_a.data);
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_expected", (done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        mon_d = done_q.pop_front();
        check("done_cycle", cyc, mon_d.cyc);
        check("busy_at_done", busy, mon_d.busy);
        check("req_at_done", mem_req, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload(input int k);
    preload_kind = k;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = (k == 0) ? 8'(i) : 8'hEE;
  endtask

  // Reference: execute the command cell by cell on mdl, logging accesses in order.
  task automatic model_cmd(input int md, input int b, input int e, input int off,
                           input int d, input int max_acc, output int nacc);
    nacc = 0;
    if (b < e) begin
      for (int k = 0; k < e - b; k++) begin
        int dst;
        int src;
        if (md == 1 || md == 2) begin
          dst = (md == 2) ? (e - 1 - k) : (b + k);
          src = (md == 2) ? ((dst - off + DEPTH) % DEPTH) : ((dst + off) % DEPTH);
          if (nacc >= max_acc) break;
          exp_q.push_back('{we: 1'b0, addr: src, data: 0});
          nacc++;
          if (nacc >= max_acc) break;
          exp_q.push_back('{we: 1'b1, addr: dst, data: int'(mdl[src])});
          mdl[dst] = mdl[src];
          nacc++;
        end else begin
          dst = b + k;
          if (nacc >= max_acc) break;
          exp_q.push_back('{we: 1'b1, addr: dst, data: d});
          mdl[dst] = 8'(d);
          nacc++;
        end
      end
    end
  endtask

  task automatic run_cmd(input int md, input int b, input int e, input int off, input int d,
                         input bit rnd_gnt, input int poke, input int abort_at);
    int nacc, t, done_at, ones, limit, c, idx;
    bit pat[$];
    model_cmd(md, b, e, off, d, (abort_at > 0) ? abort_at - 1 : 32'h3fffffff, nacc);
    ones = 0;
    while (ones < nacc) begin
      bit g;
      g = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      pat.push_back(g);
      if (g) ones++;
    end
    t = cyc;
    done_at = (nacc == 0) ? t + 1 : t + 1 + pat.size();
    if (abort_at == 0) done_q.push_back('{cyc: done_at, busy: (nacc == 0)});
    start = 1'b1; mode = 2'(md); cmd_begin = AW'(b); cmd_end = AW'(e);
    cmd_offset = AW'(off); cmd_data = DW'(d);
    limit = (abort_at > 0) ? abort_at : done_at - t + 1;
    for (int k = 0; k < limit; k++) begin
      tick();
      c = cyc - t;
      start = (c == poke);
      mode = 2'($urandom); cmd_begin = AW'($urandom); cmd_end = AW'($urandom);
      cmd_offset = AW'($urandom); cmd_data = DW'($urandom);
      idx = c - 1;
      mem_gnt = (idx < pat.size()) ? pat[idx] : 1'b1;
      if (abort_at > 0 && c == abort_at) rst = 1'b1;
      if (c == 1) begin
        @(negedge clk);
        check("busy_rise", busy, 1);
      end
    end
    start = 1'b0;
    if (abort_at > 0) begin
      tick();
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_req", mem_req, 0);
      check("abort_we", mem_we, 0);
      check("abort_addr", mem_addr, 0);
      check("abort_wdata", mem_wdata, 0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
    end else begin
      check("done_seen", done_q.size(), 0);
    end
    check("acc_drained", exp_q.size(), 0);
  endtask

  task automatic ram_check(input string nm);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== mdl[i]) bad++;
    check(nm, bad, 0);
  endtask

  initial begin
    int b, e;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    tick();
    rst = 1'b0;
    do_preload(1);

    run_cmd(BLIT_FILL, 0, TERM_COLS * TERM_ROWS, 0, 8'h20, 1'b0, 0, 0);
    ram_check("fill_ram");
    check("fill_cell1919", ram[1919], 8'h20);

    do_preload(0);
    run_cmd(BLIT_COPY_UP, 0, TERM_COLS * (TERM_ROWS - 1), TERM_COLS, 0, 1'b0, 0, 0);
    ram_check("up_ram");
    check("up_cell0", ram[0], 8'd80);
    check("up_last_row", ram[1900], 8'd108);

    do_preload(0);
    run_cmd(BLIT_COPY_DOWN, TERM_COLS, TERM_COLS * TERM_ROWS, TERM_COLS, 0, 1'b0, 0, 0);
    ram_check("down_ram");
    check("down_cell1919", ram[1919], 8'd47);
    check("down_row0", ram[79], 8'd79);

    do_preload(0);
    run_cmd(BLIT_COPY_UP, 0, 16, 4, 0, 1'b1, 0, 0);
    ram_check("rndgnt_ram");
    check("rndgnt_cell0", ram[0], 8'd4);

    for (int n = 0; n < 8; n++) begin
      b = $urandom_range(0, DEPTH - 1);
      e = b + $urandom_range(1, 24);
      if (e > DEPTH - 1) e = DEPTH - 1;
      run_cmd($urandom_range(0, 3), b, e, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
              1'b1, 0, 0);
    end
    ram_check("random_ram");

    run_cmd(BLIT_FILL, 5, 5, 0, 8'h11, 1'b0, 1, 0);
    run_cmd(BLIT_COPY_UP, 9, 3, 2, 0, 1'b0, 1, 0);
    run_cmd(BLIT_FILL, 0, 20, 0, 8'h55, 1'b0, 5, 0);
    ram_check("busy_start_ram");

    do_preload(1);
    run_cmd(BLIT_FILL, 0, 100, 0, 8'h33, 1'b0, 0, 10);
    ram_check("abort_ram");
    check("abort_cell8", ram[8], 8'h33);
    check("abort_cell9", ram[9], 8'hEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
